// File: rtl/prbs_gen.sv
// prbs_gen: N-bit maximal-length Fibonacci LFSR presenting its full state as a parallel random word.
// Optional macro PRBS_ZERO_GUARD_EN reloads SEED if the state is ever found all-zero.
module prbs_gen #(
  parameter int unsigned    N    = 14,
  parameter logic [N-1:0]   SEED = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] rnd
);

  if (N < 3 || N > 32) begin : g_badWidth
    $error("prbs_gen: N=%0d is outside the supported range 3..32", N);
  end

  if (SEED == '0) begin : g_badSeed
    $error("prbs_gen: SEED must be nonzero, an all-zero LFSR never leaves zero");
  end

  function automatic logic [31:0] tapBit(input int unsigned t);
    return 32'd1 << (t - 1);
  endfunction

  // Feedback polynomial for each width; bit t-1 set means tap t contributes to the XOR.
  function automatic logic [N-1:0] tapsFor(input int unsigned n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tapBit(3)  | tapBit(2);
      4:  m = tapBit(4)  | tapBit(3);
      5:  m = tapBit(5)  | tapBit(3);
      6:  m = tapBit(6)  | tapBit(5);
      7:  m = tapBit(7)  | tapBit(6);
      8:  m = tapBit(8)  | tapBit(6)  | tapBit(5)  | tapBit(4);
      9:  m = tapBit(9)  | tapBit(5);
      10: m = tapBit(10) | tapBit(7);
      11: m = tapBit(11) | tapBit(9);
      12: m = tapBit(12) | tapBit(6)  | tapBit(4)  | tapBit(1);
      13: m = tapBit(13) | tapBit(4)  | tapBit(3)  | tapBit(1);
      14: m = tapBit(14) | tapBit(13) | tapBit(12) | tapBit(2);
      15: m = tapBit(15) | tapBit(14);
      16: m = tapBit(16) | tapBit(15) | tapBit(13) | tapBit(4);
      17: m = tapBit(17) | tapBit(14);
      18: m = tapBit(18) | tapBit(11);
      19: m = tapBit(19) | tapBit(6)  | tapBit(2)  | tapBit(1);
      20: m = tapBit(20) | tapBit(17);
      21: m = tapBit(21) | tapBit(19);
      22: m = tapBit(22) | tapBit(21);
      23: m = tapBit(23) | tapBit(18);
      24: m = tapBit(24) | tapBit(23) | tapBit(22) | tapBit(17);
      25: m = tapBit(25) | tapBit(22);
      26: m = tapBit(26) | tapBit(6)  | tapBit(2)  | tapBit(1);
      27: m = tapBit(27) | tapBit(5)  | tapBit(2)  | tapBit(1);
      28: m = tapBit(28) | tapBit(25);
      29: m = tapBit(29) | tapBit(27);
      30: m = tapBit(30) | tapBit(6)  | tapBit(4)  | tapBit(1);
      31: m = tapBit(31) | tapBit(28);
      32: m = tapBit(32) | tapBit(22) | tapBit(2)  | tapBit(1);
      default: m = '0;
    endcase
    return m[N-1:0];
  endfunction

  localparam logic [N-1:0] TAPS = tapsFor(N);

  logic [N-1:0] r_state;
  logic [N-1:0] w_next;
  logic         w_fb;

  assign w_fb = ^(r_state & TAPS);

  always_comb begin
    w_next = {r_state[N-2:0], w_fb};
`ifdef PRBS_ZERO_GUARD_EN
    if (r_state == '0) begin
      w_next = SEED;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SEED;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef PRBS_ZERO_GUARD_EN
  // Lock-up means something upset the register; flag it even though the guard recovers.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (r_state != '0)
        else $error("prbs_gen: all-zero state detected, reloading SEED");
    end
  end
`endif

  assign rnd = r_state;

endmodule

// File: tb/tb_prbs_gen.sv
// tb_prbs_gen: directed scoreboard bench for prbs_gen at N=14 (default SEED) and N=4 (SEED=1).
// Define PRBS_ZERO_GUARD_EN for both RTL and bench to check the zero-guard build.
module tb_prbs_gen;

  localparam logic [13:0] SEED14 = 14'h3FFF;
  localparam logic [3:0]  SEED4  = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] rnd14;
  logic [3:0]  rnd4;

  int checks = 0;
  int errors = 0;

  logic [13:0] q14[$];
  logic [3:0]  q4[$];
  logic [13:0] model14;
  logic [3:0]  model4;
  bit          seen14[16384];

  logic [13:0] first14[4];
  logic [3:0]  first4[4];

  prbs_gen dut14 (
    .clk (clk),
    .rst (rst),
    .rnd (rnd14)
  );

  prbs_gen #(.N(4), .SEED(SEED4)) dut4 (
    .clk (clk),
    .rst (rst),
    .rnd (rnd4)
  );

  always #5 clk = ~clk;

  // Reference steps written from the polynomials x^14+x^13+x^12+x^2+1 and x^4+x^3+1.
  function automatic logic [13:0] step14(input logic [13:0] s);
    logic fb;
`ifdef PRBS_ZERO_GUARD_EN
    if (s == 14'h0) return SEED14;
`endif
    fb = s[13] ^ s[12] ^ s[11] ^ s[1];
    return {s[12:0], fb};
  endfunction

  function automatic logic [3:0] step4(input logic [3:0] s);
    logic fb;
`ifdef PRBS_ZERO_GUARD_EN
    if (s == 4'h0) return SEED4;
`endif
    fb = s[3] ^ s[2];
    return {s[2:0], fb};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drives rst at the falling edge, records the expected state, and returns just after the rising edge.
  task automatic applyStimulus(input logic rstVal);
    @(negedge clk);
    rst = rstVal;
    if (!rstVal) begin
      model14 = SEED14;
      model4  = SEED4;
    end else begin
      model14 = step14(model14);
      model4  = step4(model4);
    end
    q14.push_back(model14);
    q4.push_back(model4);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [13:0] e14;
    logic [3:0]  e4;
    e14 = q14.pop_front();
    e4  = q4.pop_front();
    checkVal({tag, "/n14"}, {18'h0, rnd14}, {18'h0, e14});
    checkVal({tag, "/n4"},  {28'h0, rnd4},  {28'h0, e4});
  endtask

  initial begin
    int seqBad, early, dup, zeroCnt, ret4;
    logic [13:0] e14;
    logic [3:0]  e4;

    first14 = '{14'h3FFE, 14'h3FFC, 14'h3FF9, 14'h3FF3};
    first4  = '{4'h2, 4'h4, 4'h9, 4'h3};
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      checkOutput("resetHold");
    end

    // Full period: every nonzero state once, SEED only at the final step.
    seqBad = 0; early = 0; dup = 0; zeroCnt = 0; ret4 = 0;
    for (int i = 0; i < 16384; i++) seen14[i] = 1'b0;
    seen14[SEED14] = 1'b1;
    for (int k = 1; k <= 16383; k++) begin
      applyStimulus(1'b1);
      e14 = q14.pop_front();
      e4  = q4.pop_front();
      if (k <= 4) begin
        checkVal("firstRun14", {18'h0, rnd14}, {18'h0, first14[k-1]});
        checkVal("firstRun4",  {28'h0, rnd4},  {28'h0, first4[k-1]});
      end
      if (rnd14 !== e14 || rnd4 !== e4) seqBad++;
      if (rnd14 === 14'h0) zeroCnt++;
      if (k < 16383) begin
        if (rnd14 === SEED14) early++;
        else if (seen14[rnd14]) dup++;
        seen14[rnd14] = 1'b1;
      end else begin
        checkVal("periodEnd14", {18'h0, rnd14}, {18'h0, SEED14});
      end
      if (rnd4 === SEED4 && ret4 == 0) ret4 = k;
    end
    checkVal("seqModel", seqBad, 0);
    checkVal("earlyRepeat14", early, 0);
    checkVal("duplicate14", dup, 0);
    checkVal("zeroSeen14", zeroCnt, 0);
    checkVal("period4", ret4, 15);

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1);
      checkOutput("run");
    end

    // One-edge reset mid-run must replay the sequence from SEED.
    applyStimulus(1'b0);
    checkOutput("midReset");
    checkVal("midResetSeed", {18'h0, rnd14}, {18'h0, SEED14});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      checkOutput("replay");
      checkVal("replay14", {18'h0, rnd14}, {18'h0, first14[i]});
      checkVal("replay4",  {28'h0, rnd4},  {28'h0, first4[i]});
    end

    force dut14.r_state = 14'h0;
    #1;
    release dut14.r_state;
    #1;
    checkVal("forcedZero", {18'h0, rnd14}, 32'h0);
    model14 = 14'h0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1);
      checkOutput("afterZero");
    end

    applyStimulus(1'b0);
    checkOutput("recover");
    applyStimulus(1'b1);
    checkOutput("recoverStep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
